// File: rtl/bus_rr_scheduler.sv
// Round-robin scheduler moving one packet per 3 cycles from a source FIFO to its destination(s).
// Optional BUS_SCHED_STATS_EN builds the delivered/dropped packet counters.
module bus_rr_scheduler #(
  parameter int unsigned Drvrs     = 5,
  parameter int unsigned PckgSz    = 16,
  parameter logic [7:0]  Broadcast = 8'hFF
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [Drvrs-1:0]         pndng_i,
  input  logic [Drvrs*PckgSz-1:0]  d_pop_i,
  output logic [Drvrs-1:0]         pop_o,
  output logic [Drvrs-1:0]         push_o,
  output logic [PckgSz-1:0]        d_push_o,
  output logic                     busy_o,
  output logic [15:0]              pkt_cnt_o,
  output logic [15:0]              drop_cnt_o
);

  localparam int unsigned IdxW = (Drvrs > 1) ? $clog2(Drvrs) : 1;

  typedef enum logic [1:0] {StIdle, StPop, StPush} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     ptr_q, ptr_d;
  logic [IdxW-1:0]     grant_q, grant_d;
  logic [PckgSz-1:0]   pkt_q, pkt_d;
  logic [Drvrs-1:0]    push_q, push_d;
  logic [PckgSz-1:0]   d_push_q, d_push_d;

  logic                gnt_found;
  logic [IdxW-1:0]     gnt_idx;
  logic [IdxW:0]       cand;
  logic [7:0]          dest;
  logic [Drvrs-1:0]    mask;
  logic [IdxW-1:0]     next_ptr;

  // First pending requester at or after ptr, with wrap-around.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < Drvrs; k++) begin
      cand = {1'b0, ptr_q} + (IdxW+1)'(k);
      if (cand >= (IdxW+1)'(Drvrs)) begin
        cand = cand - (IdxW+1)'(Drvrs);
      end
      if (!gnt_found && pndng_i[cand[IdxW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IdxW-1:0];
      end
    end
  end

  assign dest     = pkt_q[PckgSz-1 -: 8];
  assign next_ptr = (grant_q == IdxW'(Drvrs - 1)) ? '0 : grant_q + 1'b1;

  // Self-addressed and out-of-range destinations leave the mask empty (drop).
  always_comb begin
    mask = '0;
    if (dest == Broadcast) begin
      mask          = '1;
      mask[grant_q] = 1'b0;
    end else if ((dest < 8'(Drvrs)) && (dest != 8'(grant_q))) begin
      mask[dest[IdxW-1:0]] = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    pkt_d    = pkt_q;
    push_d   = '0;
    d_push_d = d_push_q;
    pop_o    = '0;
    case (state_q)
      StIdle: begin
        // pop is combinational so the FIFO drops its head on the edge that latches it.
        if (gnt_found && !reset_i) begin
          pop_o[gnt_idx] = 1'b1;
          grant_d        = gnt_idx;
          pkt_d          = d_pop_i[gnt_idx*PckgSz +: PckgSz];
          state_d        = StPop;
        end
      end
      StPop: begin
        ptr_d    = next_ptr;
        push_d   = mask;
        d_push_d = pkt_q;
        state_d  = StPush;
      end
      StPush: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      grant_q  <= '0;
      pkt_q    <= '0;
      push_q   <= '0;
      d_push_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      pkt_q    <= pkt_d;
      push_q   <= push_d;
      d_push_q <= d_push_d;
    end
  end

  assign push_o   = push_q;
  assign d_push_o = d_push_q;
  assign busy_o   = (state_q != StIdle);

`ifdef BUS_SCHED_STATS_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if ((state_q == StPop) && (mask == '0) && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
    if ((state_q == StPush) && (push_q != '0) && (pkt_cnt_q != 16'hFFFF)) begin
      pkt_cnt_d = pkt_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign pkt_cnt_o  = pkt_cnt_q;
  assign drop_cnt_o = drop_cnt_q;
`else
  assign pkt_cnt_o  = 16'h0000;
  assign drop_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Directed bench for bus_rr_scheduler: single, broadcast, drops, wrap priority, reset, round robin.
module tb_bus_rr_scheduler;

  localparam int unsigned Drvrs  = 5;
  localparam int unsigned PckgSz = 16;
`ifdef BUS_SCHED_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    reset;
  logic [Drvrs-1:0]        pndng;
  logic [Drvrs*PckgSz-1:0] d_pop;
  logic [Drvrs-1:0]        pop;
  logic [Drvrs-1:0]        push;
  logic [PckgSz-1:0]       d_push;
  logic                    busy;
  logic [15:0]             pkt_cnt;
  logic [15:0]             drop_cnt;

  int checks = 0;
  int errors = 0;

  bus_rr_scheduler #(
    .Drvrs     (Drvrs),
    .PckgSz    (PckgSz),
    .Broadcast (8'hFF)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .pndng_i    (pndng),
    .d_pop_i    (d_pop),
    .pop_o      (pop),
    .push_o     (push),
    .d_push_o   (d_push),
    .busy_o     (busy),
    .pkt_cnt_o  (pkt_cnt),
    .drop_cnt_o (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] cnt_exp(input int n);
    return StatsEn ? 16'(n) : 16'h0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [15:0] v);
    d_pop[i*PckgSz +: PckgSz] = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] exp_v;
    reset = 1'b1;
    pndng = '1;
    d_pop = '0;
    tick();
    tick();
    chk("rst_pop", 32'(pop), 32'h0);
    chk("rst_push", 32'(push), 32'h0);
    chk("rst_dpush", 32'(d_push), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_pkt", 32'(pkt_cnt), 32'h0);
    chk("rst_drop", 32'(drop_cnt), 32'h0);
    reset = 1'b0;
    pndng = '0;
    tick();

    // Single transfer 1 -> 2
    set_src(1, 16'h0208);
    pndng = 5'b00010;
    #1;
    chk("s_pop", 32'(pop), 32'h02);
    chk("s_busy_idle", 32'(busy), 32'h0);
    tick();
    pndng = '0;
    chk("s_pop_gone", 32'(pop), 32'h0);
    chk("s_busy", 32'(busy), 32'h1);
    chk("s_push_early", 32'(push), 32'h0);
    tick();
    chk("s_push", 32'(push), 32'h04);
    chk("s_dpush", 32'(d_push), 32'h0208);
    chk("s_pop_push", 32'(pop), 32'h0);
    tick();
    chk("s_push_end", 32'(push), 32'h0);
    chk("s_busy_end", 32'(busy), 32'h0);
    chk("s_dpush_hold", 32'(d_push), 32'h0208);
    chk("s_pkt", 32'(pkt_cnt), 32'(cnt_exp(1)));

    // Broadcast from 3 (ptr = 2)
    set_src(3, 16'hFF55);
    pndng = 5'b01000;
    #1;
    chk("b_pop", 32'(pop), 32'h08);
    tick();
    pndng = '0;
    tick();
    chk("b_push", 32'(push), 32'h17);
    chk("b_dpush", 32'(d_push), 32'hFF55);
    tick();
    chk("b_pkt", 32'(pkt_cnt), 32'(cnt_exp(2)));

    // Drops: out-of-range from 0 (ptr = 4 wraps to 0), then self-addressed from 2
    set_src(0, 16'h0700);
    pndng = 5'b00001;
    #1;
    chk("d0_pop", 32'(pop), 32'h01);
    tick();
    pndng = '0;
    tick();
    chk("d0_push", 32'(push), 32'h0);
    chk("d0_drop", 32'(drop_cnt), 32'(cnt_exp(1)));
    tick();
    set_src(2, 16'h0201);
    pndng = 5'b00100;
    #1;
    chk("d2_pop", 32'(pop), 32'h04);
    tick();
    pndng = '0;
    tick();
    chk("d2_push", 32'(push), 32'h0);
    tick();
    chk("d_drop", 32'(drop_cnt), 32'(cnt_exp(2)));
    chk("d_pkt", 32'(pkt_cnt), 32'(cnt_exp(2)));

    // Priority from ptr = 3 with everyone pending
    set_src(3, 16'h0011);
    pndng = 5'b11111;
    #1;
    chk("w_pop", 32'(pop), 32'h08);
    tick();
    pndng = '0;
    tick();
    chk("w_push", 32'(push), 32'h01);
    tick();
    chk("w_pkt", 32'(pkt_cnt), 32'(cnt_exp(3)));

    // Reset during POP (ptr = 4 -> grant 0)
    set_src(0, 16'h0304);
    pndng = 5'b00001;
    #1;
    chk("r_pop", 32'(pop), 32'h01);
    tick();
    reset = 1'b1;
    pndng = '0;
    #1;
    chk("r_push_pop", 32'(push), 32'h0);
    tick();
    chk("r_push", 32'(push), 32'h0);
    chk("r_busy", 32'(busy), 32'h0);
    chk("r_dpush", 32'(d_push), 32'h0);
    chk("r_pkt", 32'(pkt_cnt), 32'h0);
    chk("r_drop", 32'(drop_cnt), 32'h0);
    reset = 1'b0;

    // Round robin, all pending, dest = src+1
    for (int i = 0; i < 5; i++) begin
      set_src(i, {8'((i + 1) % 5), 8'(i)});
    end
    pndng = 5'b11111;
    #1;
    for (int k = 0; k < 6; k++) begin
      exp_v = 5'b00001 << (k % 5);
      chk("rr_pop", 32'(pop), 32'(exp_v));
      tick();
      chk("rr_pop_gap", 32'(pop), 32'h0);
      tick();
      exp_v = 5'b00001 << ((k + 1) % 5);
      chk("rr_push", 32'(push), 32'(exp_v));
      chk("rr_dpush", 32'(d_push), 32'({8'(((k % 5) + 1) % 5), 8'(k % 5)}));
      tick();
    end
    chk("rr_pkt", 32'(pkt_cnt), 32'(cnt_exp(6)));
    chk("rr_drop", 32'(drop_cnt), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_rr_scheduler.md
# bus_rr_scheduler

Round-robin scheduler that shares one bus transfer slot among `drvrs` source FIFOs. Each granted transfer pops one packet from the selected source FIFO, decodes its destination byte, and pushes it into the destination FIFO, or into every other FIFO for broadcast. It sits between the per-driver FIFO interfaces (`pndng`/`pop`/`D_pop` and `push`/`D_push`) and replaces the fixed arbitration of the bus generator with a scheduler that enforces fairness and accounts for dropped packets.

## Interface
- `drvrs`, 5: number of drivers/FIFOs (2..16).
- `pckg_sz`, 16: packet width. Bits `[pckg_sz-1:pckg_sz-8]` hold the destination ID; the lower bits are payload.
- `broadcast`, `{8{1'b1}}`: destination ID meaning "all drivers".
- `clk`  in  1  single clock; all logic updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pndng`  in  drvrs  bit i high means FIFO i is non-empty and its head is valid on `D_pop` (first-word fall-through).
- `D_pop`  in  drvrs*pckg_sz  head packet of FIFO i on bits `[i*pckg_sz +: pckg_sz]`.
- `pop`  out  drvrs  one-hot, one-cycle pulse that removes the head of FIFO i.
- `push`  out  drvrs  one-cycle push strobes into destination FIFOs.
- `D_push`  out  pckg_sz  packet written by `push`; shared by all destinations.
- `busy`  out  1  high while the FSM is not in IDLE.
- `pkt_cnt`  out  16  count of delivered packets, saturating at 16'hFFFF.
- `drop_cnt`  out  16  count of dropped packets, saturating at 16'hFFFF.

## Operation
- State `ptr` (range 0..drvrs-1) is the highest-priority requester.
- Grant rule: the first i with `pndng[i]` high, searching `ptr, ptr+1, …` with wrap-around modulo `drvrs`.
- FSM states:
  - **IDLE**
    - If any `pndng` bit is high, grant index g.
    - Latch `D_pop[g]` into `pkt_q`, assert `pop[g]`, and go to POP.
    - Otherwise stay in IDLE.
  - **POP**
    - Set `ptr` = (g+1) mod drvrs.
    - Decode `dest` = `pkt_q[pckg_sz-1 -: 8]`.
    - If `dest == broadcast`, set the push mask to all ones except bit g.
    - Else if `dest < drvrs` and `dest != g`, set the push mask to one-hot `dest`.
    - Otherwise the packet is dropped: the mask is zero and `drop_cnt` increments.
    - Go to PUSH.
  - **PUSH**
    - Drive `push` = mask and `D_push` = `pkt_q`.
    - Increment `pkt_cnt` if the mask is non-zero.
    - Return to IDLE.
- `D_push` holds its last value outside PUSH.
- `pndng` changes during POP or PUSH have no effect until the next IDLE evaluation.
- Self-addressed packets (`dest == g`) and out-of-range destination IDs are dropped.

## Timing
- Reset values: `pop` = 0, `push` = 0, `D_push` = 0, `busy` = 0, `pkt_cnt` = 0, `drop_cnt` = 0, `ptr` = 0, state = IDLE.
- Per packet: `pop` in cycle N (IDLE→POP edge), `push` in cycle N+2. There is exactly one packet in flight.
- Throughput: one packet every 3 cycles under continuous requests.
- `pop` and `push` are never asserted in the same cycle.
- Each is asserted for exactly one cycle per packet.
- `busy` rises at the edge that leaves IDLE and falls at the edge that enters IDLE.
- Simultaneous requests are resolved only by `ptr`. With all FIFOs pending, the grant order is `ptr, ptr+1, …`, and no source waits more than `drvrs-1` grants.
- Reset asserted mid-transfer: next edge returns to reset values; a popped but not yet pushed packet is lost (not counted).
- Counter saturation: `pkt_cnt`/`drop_cnt` stay at 16'hFFFF once reached.

## Configuration
- `BUS_SCHED_STATS_EN`
  - Defined: `pkt_cnt` and `drop_cnt` are implemented as described above.
  - Undefined: no counter registers are built and both outputs are tied to 16'h0000.
  - Scheduling, grant order, drop decisions and timing are identical in both cases.

## Test plan
Defaults: `drvrs`=5, `pckg_sz`=16, `broadcast`=8'hFF.
- **Single transfer:** `pndng[1]`=1, `D_pop[1]`=16'h0208. Expect `pop`=5'b00010 at cycle N, `push`=5'b00100 with `D_push`=16'h0208 at N+2, and `pkt_cnt`=1.
- **Broadcast:** `pndng[3]`=1, `D_pop[3]`=16'hFF55. Expect `push`=5'b10111 and `D_push`=16'hFF55.
- **Round robin:** all `pndng`=5'b11111 held high after reset, each packet destined for (src+1) mod 5. Expect grants in order 0,1,2,3,4,0, spaced 3 cycles apart.
- **Drops:** `D_pop[0]`=16'h0700 (out of range), then `D_pop[2]`=16'h0201 (self-addressed). Expect `pop` pulses, no `push`, and `drop_cnt`=2.
- **Reset mid-operation:** assert `reset` in the POP cycle. Expect `push` to stay 0, all outputs at reset values next cycle, and `ptr` restarted so driver 0 is granted first.
- **Config check:** with `BUS_SCHED_STATS_EN` undefined, rerun the round-robin scenario. Expect the same grant order and `pkt_cnt`=`drop_cnt`=0.
